// File: rtl/quet_led7_if.sv
// quet_led7_if -- signal bundle between the display-data producer and the
// 4-digit 7-segment scanner.
//
// Signals:
//   EN      producer -> scanner  scan enable (0 = blank, counters cleared)
//   BRIGHT  producer -> scanner  brightness, on-time in eighths minus one
//   HEX0..3 producer -> scanner  active-low segment bytes {dp,g..a}
//   SEG     scanner -> producer  shared active-low segment bus
//   DIG     scanner -> producer  active-low one-hot digit enables
//   FRAME   scanner -> producer  one-cycle pulse at frame start
//
// Modports:
//   master  the side that supplies digit data (decoder / testbench)
//   slave   the scanner itself
interface quet_led7_if;
    logic       EN;
    logic [2:0] BRIGHT;
    logic [7:0] HEX0;
    logic [7:0] HEX1;
    logic [7:0] HEX2;
    logic [7:0] HEX3;
    logic [7:0] SEG;
    logic [3:0] DIG;
    logic       FRAME;

    modport master (
        output EN, BRIGHT, HEX0, HEX1, HEX2, HEX3,
        input  SEG, DIG, FRAME
    );

    modport slave (
        input  EN, BRIGHT, HEX0, HEX1, HEX2, HEX3,
        output SEG, DIG, FRAME
    );
endinterface

// File: rtl/quet_led7.sv
// quet_led7 -- time-multiplexed 4-digit 7-segment scanner.
//
// Each digit owns a slot of SLOT_CYC clocks. The first DEAD clocks of every
// slot are blanked so the previous digit's segments cannot ghost onto the
// next one, then the digit stays lit for a PWM window set by BRIGHT. The
// four segment bytes and BRIGHT are captured into shadow registers at the
// start of every frame so a frame never shows a mix of old and new data.
//
// Ports:
//   CK   system clock, rising edge
//   RS   asynchronous active-high reset
//   bus  quet_led7_if.slave: EN, BRIGHT, HEX0..3 in; SEG, DIG, FRAME out
//        (all outputs registered, one cycle behind the scan position)
//
// Parameters:
//   SLOT_CYC  clocks per digit slot (>= 8 and > DEAD)
//   DEAD      blanked clocks at the start of each slot
module quet_led7 #(
    parameter int SLOT_CYC = 1000,
    parameter int DEAD     = 2
) (
    input  logic        CK,
    input  logic        RS,
    quet_led7_if.slave  bus
);

    localparam int              CW       = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(SLOT_CYC - 1);
    localparam logic [31:0]     LIT_SPAN = 32'(SLOT_CYC - DEAD);
    localparam logic [31:0]     DEAD_U   = 32'(DEAD);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [7:0]    r_shadow [4];
    logic [2:0]    r_bright;
    logic [7:0]    r_seg;
    logic [3:0]    r_dig;
    logic          r_frame;

    logic [31:0]   w_onCyc;
    logic [31:0]   w_rel;
    logic          w_slotEnd;
    logic          w_lit;
    logic          w_snap;

    // PWM on-time in clocks; the product is formed at 32 bits so nothing is
    // lost before the divide-by-eight.
    assign w_onCyc = ((32'(r_bright) + 32'd1) * LIT_SPAN) >> 3;

    // Position inside the lit region. During dead time the subtraction wraps
    // to a huge value, so a single unsigned compare covers both bounds.
    assign w_rel     = 32'(r_cnt) - DEAD_U;
    assign w_lit     = (r_state == SCAN) && (w_rel < w_onCyc);
    assign w_slotEnd = (r_cnt == LAST_CNT);

    // The snapshot is taken on every edge that lands on digit 0 / count 0:
    // leaving IDLE, or wrapping past digit 3 while still enabled. A disable
    // on the wrap edge wins, so no snapshot then.
    assign w_snap = bus.EN &&
                    ((r_state == IDLE) ||
                     (w_slotEnd && (r_idx == 2'd3)));

    always_ff @(posedge CK or posedge RS) begin
        if (RS) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_bright <= '0;
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= 8'hFF;
            end
            r_seg    <= 8'hFF;
            r_dig    <= 4'b1111;
            r_frame  <= 1'b0;
        end else begin
            // Outputs reflect the current scan position, hence one cycle of lag.
            if (w_lit) begin
                r_dig <= ~(4'b0001 << r_idx);
                r_seg <= r_shadow[r_idx];
            end else begin
                r_dig <= 4'b1111;
                r_seg <= 8'hFF;
            end
            r_frame <= (r_state == SCAN) && (r_idx == 2'd0) && (r_cnt == '0);

            if (w_snap) begin
                r_shadow[0] <= bus.HEX0;
                r_shadow[1] <= bus.HEX1;
                r_shadow[2] <= bus.HEX2;
                r_shadow[3] <= bus.HEX3;
                r_bright    <= bus.BRIGHT;
            end

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    if (bus.EN) begin
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (!bus.EN) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end else if (w_slotEnd) begin
                        r_cnt <= '0;
                        r_idx <= r_idx + 2'd1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign bus.SEG   = r_seg;
    assign bus.DIG   = r_dig;
    assign bus.FRAME = r_frame;

endmodule
